// File: rtl/riscv_dcache_nway.sv
// riscv_dcache_nway
// Blocking, write-back, write-allocate L1 data cache with 1/2/4-way set
// associativity and tree pseudo-LRU replacement. The CPU side is a 64-bit
// port that is looked up combinationally. The memory side moves whole lines.
// A miss evicts a victim: it writes the victim back if it is dirty, then
// refills the way. The held request then hits in IDLE, and any store is
// merged into the line on that hit cycle.
module riscv_dcache_nway #(
    parameter int DATA_WIDTH = 128,
    parameter int CACHE_SIZE = 4096,
    parameter int WAYS       = 2,
    parameter int MEM_SIZE   = 128*(2**20),
    localparam int DATAPBLOCK = DATA_WIDTH/8,
    localparam int ADDR       = $clog2(MEM_SIZE),
    localparam int BYTE_OFF   = $clog2(DATAPBLOCK),
    localparam int S_ADDR     = ADDR - BYTE_OFF
) (
    input  logic                  i_riscv_dcache_clk,
    input  logic                  i_riscv_dcache_rst,
    input  logic                  i_riscv_dcache_globstall,
    input  logic                  i_riscv_dcache_cpu_wren,
    input  logic                  i_riscv_dcache_cpu_rden,
    input  logic [1:0]            i_riscv_dcache_store_src,
    input  logic [ADDR-1:0]       i_riscv_dcache_phys_addr,
    input  logic [63:0]           i_riscv_dcache_cpu_data_in,
    output logic [63:0]           o_riscv_dcache_cpu_data_out,
    output logic                  o_riscv_dcache_cpu_stall,
    output logic [S_ADDR-1:0]     o_riscv_dcache_mem_addr,
    output logic                  o_riscv_dcache_mem_wren,
    output logic                  o_riscv_dcache_mem_rden,
    output logic [DATA_WIDTH-1:0] o_riscv_dcache_mem_data_out,
    input  logic [DATA_WIDTH-1:0] i_riscv_dcache_mem_data_in,
    input  logic                  i_riscv_dcache_mem_ready
);

    localparam int SETS  = CACHE_SIZE / (DATAPBLOCK * WAYS);
    localparam int INDEX = $clog2(SETS);
    localparam int TAG   = ADDR - INDEX - BYTE_OFF;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LRU_W = (WAYS > 1) ? (WAYS - 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WB    = 2'd1;
    localparam logic [1:0] ST_ALLOC = 2'd2;

    if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
        $error("riscv_dcache_nway: WAYS must be 1, 2 or 4");
    end

    // Way that the pLRU bits point at. For 4 ways, bit0 selects the half
    // (0 = ways 0/1), bit1 selects inside the lower half and bit2 inside
    // the upper half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] bits);
        logic [2:0] b;
        logic [1:0] v;
        b = 3'(bits);
        case (WAYS)
            2:       v = {1'b0, b[0]};
            4:       v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
            default: v = 2'b00;
        endcase
        return WAY_W'(v);
    endfunction

    // Re-point the pLRU bits away from the way that was just used.
    function automatic logic [LRU_W-1:0] plru_update(input logic [LRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0] way);
        logic [2:0] b;
        logic [1:0] w;
        b = 3'(bits);
        w = 2'(way);
        case (WAYS)
            2: b[0] = ~w[0];
            4: begin
                b[0] = ~w[1];
                if (w[1]) begin
                    b[2] = ~w[0];
                end else begin
                    b[1] = ~w[0];
                end
            end
            default: b = 3'b000;
        endcase
        return LRU_W'(b);
    endfunction

    // Merge a B/H/W/D store into a line at the given byte offset.
    function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] line,
                                                          input logic [63:0] wdata,
                                                          input logic [1:0] size,
                                                          input logic [BYTE_OFF-1:0] off);
        logic [63:0]           m64;
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] data;
        case (size)
            2'b00:   m64 = 64'h0000_0000_0000_00FF;
            2'b01:   m64 = 64'h0000_0000_0000_FFFF;
            2'b10:   m64 = 64'h0000_0000_FFFF_FFFF;
            default: m64 = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mask = DATA_WIDTH'(m64) << {off, 3'b000};
        data = DATA_WIDTH'(wdata & m64) << {off, 3'b000};
        return (line & ~mask) | data;
    endfunction

    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS];
    logic [TAG-1:0]        tag_q   [WAYS][SETS];
    logic [SETS-1:0]       valid_q [WAYS];
    logic [SETS-1:0]       dirty_q [WAYS];
    logic [SETS*LRU_W-1:0] lru_q;
    logic [1:0]            state_q, state_d;
    logic [WAY_W-1:0]      victim_q, victim_d;

    logic [INDEX-1:0]      idx_s;
    logic [TAG-1:0]        tag_s;
    logic [BYTE_OFF-1:0]   off_s;
    logic                  req_s;
    logic [WAYS-1:0]       hit_vec_s;
    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [DATA_WIDTH-1:0] hit_line_s;
    logic [LRU_W-1:0]      lru_cur_s;
    logic                  any_inv_s;
    logic [WAY_W-1:0]      inv_way_s;
    logic [WAY_W-1:0]      victim_s;
    logic                  cpu_upd_s;
    logic                  fill_s;

    assign idx_s     = i_riscv_dcache_phys_addr[BYTE_OFF +: INDEX];
    assign tag_s     = i_riscv_dcache_phys_addr[ADDR-1 -: TAG];
    assign off_s     = i_riscv_dcache_phys_addr[BYTE_OFF-1:0];
    assign req_s     = i_riscv_dcache_cpu_wren | i_riscv_dcache_cpu_rden;
    assign lru_cur_s = lru_q[idx_s*LRU_W +: LRU_W];
    assign hit_s     = |hit_vec_s;
    assign victim_s  = any_inv_s ? inv_way_s : plru_victim(lru_cur_s);
    assign cpu_upd_s = (state_q == ST_IDLE) && req_s && hit_s && !i_riscv_dcache_globstall;
    assign fill_s    = (state_q == ST_ALLOC) && i_riscv_dcache_mem_ready;

    // Tag compare across all ways of the addressed set; at most one way matches.
    always_comb begin
        hit_vec_s  = '0;
        hit_way_s  = '0;
        hit_line_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_q[w][idx_s] && (tag_q[w][idx_s] == tag_s);
            hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
            hit_line_s   = hit_vec_s[w] ? data_q[w][idx_s] : hit_line_s;
        end
    end

    // Lowest-index invalid way; scanning downward leaves the lowest one.
    always_comb begin
        any_inv_s = 1'b0;
        inv_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            any_inv_s = any_inv_s | !valid_q[w][idx_s];
            inv_way_s = !valid_q[w][idx_s] ? WAY_W'(w) : inv_way_s;
        end
    end

    // Miss handling sequence: IDLE -> (WRITEBACK) -> ALLOCATE -> IDLE.
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && !hit_s) begin
                    victim_d = victim_s;
                    state_d  = (valid_q[victim_s][idx_s] && dirty_q[victim_s][idx_s]) ? ST_WB : ST_ALLOC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (i_riscv_dcache_mem_ready) begin
                    state_d = ST_ALLOC;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_ALLOC: begin
                if (i_riscv_dcache_mem_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALLOC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, victim pointer and per-line valid/dirty/pLRU bits.
    always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
        if (i_riscv_dcache_rst) begin
            state_q  <= ST_IDLE;
            victim_q <= '0;
            lru_q    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (fill_s) begin
                valid_q[victim_q][idx_s] <= 1'b1;
                dirty_q[victim_q][idx_s] <= 1'b0;
            end else if (cpu_upd_s) begin
                lru_q[idx_s*LRU_W +: LRU_W] <= plru_update(lru_cur_s, hit_way_s);
                if (i_riscv_dcache_cpu_wren) begin
                    dirty_q[hit_way_s][idx_s] <= 1'b1;
                end
            end
        end
    end

    // Line data and tags: refill on allocate completion, merge on store hit.
    always_ff @(posedge i_riscv_dcache_clk) begin
        if (fill_s) begin
            data_q[victim_q][idx_s] <= i_riscv_dcache_mem_data_in;
            tag_q[victim_q][idx_s]  <= tag_s;
        end else if (cpu_upd_s && i_riscv_dcache_cpu_wren) begin
            data_q[hit_way_s][idx_s] <= store_merge(hit_line_s, i_riscv_dcache_cpu_data_in,
                                                    i_riscv_dcache_store_src, off_s);
        end
    end

    // Output decode; reset forces every output low immediately.
    always_comb begin
        o_riscv_dcache_cpu_data_out = i_riscv_dcache_phys_addr[3] ? hit_line_s[64 +: 64] : hit_line_s[63:0];
        o_riscv_dcache_cpu_stall    = (state_q != ST_IDLE) || (req_s && !hit_s);
        o_riscv_dcache_mem_wren     = (state_q == ST_WB);
        o_riscv_dcache_mem_rden     = (state_q == ST_ALLOC);
        o_riscv_dcache_mem_addr     = '0;
        o_riscv_dcache_mem_data_out = '0;
        case (state_q)
            ST_WB: begin
                o_riscv_dcache_mem_addr     = {tag_q[victim_q][idx_s], idx_s};
                o_riscv_dcache_mem_data_out = data_q[victim_q][idx_s];
            end
            ST_ALLOC: o_riscv_dcache_mem_addr = {tag_s, idx_s};
            default:  o_riscv_dcache_mem_addr = '0;
        endcase
        if (i_riscv_dcache_rst) begin
            o_riscv_dcache_cpu_data_out = '0;
            o_riscv_dcache_cpu_stall    = 1'b0;
            o_riscv_dcache_mem_wren     = 1'b0;
            o_riscv_dcache_mem_rden     = 1'b0;
            o_riscv_dcache_mem_addr     = '0;
            o_riscv_dcache_mem_data_out = '0;
        end else begin
            o_riscv_dcache_cpu_stall = o_riscv_dcache_cpu_stall;
        end
    end

endmodule

// File: tb/tb_riscv_dcache_nway.sv
// Testbench for riscv_dcache_nway (default parameters: 128-bit lines, 4 KiB, 2 ways).
module tb_riscv_dcache_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         globstall, wren, rden, mem_ready;
    logic [1:0]   store_src;
    logic [26:0]  phys_addr;
    logic [63:0]  cpu_data_in, cpu_data_out;
    logic         stall, mem_wren, mem_rden;
    logic [22:0]  mem_addr;
    logic [127:0] mem_data_out, mem_data_in;

    int checks = 0;
    int errors = 0;

    riscv_dcache_nway dut (
        .i_riscv_dcache_clk          (clk),
        .i_riscv_dcache_rst          (rst),
        .i_riscv_dcache_globstall    (globstall),
        .i_riscv_dcache_cpu_wren     (wren),
        .i_riscv_dcache_cpu_rden     (rden),
        .i_riscv_dcache_store_src    (store_src),
        .i_riscv_dcache_phys_addr    (phys_addr),
        .i_riscv_dcache_cpu_data_in  (cpu_data_in),
        .o_riscv_dcache_cpu_data_out (cpu_data_out),
        .o_riscv_dcache_cpu_stall    (stall),
        .o_riscv_dcache_mem_addr     (mem_addr),
        .o_riscv_dcache_mem_wren     (mem_wren),
        .o_riscv_dcache_mem_rden     (mem_rden),
        .o_riscv_dcache_mem_data_out (mem_data_out),
        .i_riscv_dcache_mem_data_in  (mem_data_in),
        .i_riscv_dcache_mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr, rd;
        logic [1:0]   sz;
        logic [26:0]  addr;
        logic [63:0]  wdata;
        logic         gst;
        int           dly;
        logic         miss, wb;
        logic [22:0]  wb_addr;
        logic [127:0] wb_data;
        logic [22:0]  rd_addr;
        logic         chk;
        logic [63:0]  rdata;
    } vec_t;

    // Backing DDR memory: written-back lines, otherwise a fixed pattern.
    logic [127:0] mem_model [int];

    // Reference cache state for the randomized phase (2 ways, true LRU).
    logic [15:0]  m_tag   [128][2];
    bit           m_val   [128][2];
    bit           m_dirty [128][2];
    logic [127:0] m_line  [128][2];
    int           m_mru   [128];

    function automatic logic [127:0] mem_rd(input logic [22:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return {32'h1357_0000 ^ 32'(a), 32'(a) * 32'h9E37_79B1, ~32'(a), 32'hA5A5_0000 + 32'(a)};
    endfunction

    function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] sz,
                                input logic [26:0] addr, input logic [63:0] wdata,
                                input logic gst, input int dly, input logic miss,
                                input logic wb, input logic [22:0] wb_addr,
                                input logic [127:0] wb_data, input logic [22:0] rd_addr,
                                input logic chk, input logic [63:0] rdata);
        vec_t v;
        v.wr = wr; v.rd = rd; v.sz = sz; v.addr = addr; v.wdata = wdata; v.gst = gst;
        v.dly = dly; v.miss = miss; v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.rd_addr = rd_addr; v.chk = chk; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Apply one request (entered just after a rising edge) and follow it to completion.
    task automatic run_req(input string nm, input vec_t v);
        logic [127:0] fill;
        wren = v.wr; rden = v.rd; store_src = v.sz; phys_addr = v.addr;
        cpu_data_in = v.wdata; globstall = v.gst;
        if (v.miss) begin
            @(negedge clk);
            chk({nm, "_miss_stall"}, 128'(stall), 128'd1);
            chk({nm, "_miss_nomem"}, 128'({mem_wren, mem_rden}), 128'd0);
            @(posedge clk); #1;
            if (v.wb) begin
                for (int c = 0; c <= v.dly; c++) begin
                    @(negedge clk);
                    chk({nm, "_wb_ctl"}, 128'({mem_wren, mem_rden, stall}), 128'b101);
                    chk({nm, "_wb_addr"}, 128'(mem_addr), 128'(v.wb_addr));
                    chk({nm, "_wb_data"}, mem_data_out, v.wb_data);
                    if (c == v.dly) mem_ready = 1'b1;
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                end
                mem_model[int'(v.wb_addr)] = v.wb_data;
            end
            fill = mem_rd(v.rd_addr);
            for (int c = 0; c <= v.dly; c++) begin
                @(negedge clk);
                chk({nm, "_al_ctl"}, 128'({mem_wren, mem_rden, stall}), 128'b011);
                chk({nm, "_al_addr"}, 128'(mem_addr), 128'(v.rd_addr));
                if (c == v.dly) begin
                    mem_ready = 1'b1;
                    mem_data_in = fill;
                end
                @(posedge clk); #1;
                mem_ready = 1'b0;
                mem_data_in = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        @(negedge clk);
        chk({nm, "_hit_stall"}, 128'(stall), 128'd0);
        if (v.chk) chk({nm, "_rdata"}, 128'(cpu_data_out), 128'(v.rdata));
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        mem_ready = 1'b0; wren = 1'b0; rden = 1'b0; globstall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t tbl[$];
    localparam logic [127:0] LA = 128'h0011223344556677_8899AABBCCDDEEFF;
    localparam logic [127:0] LB = 128'hB0B1B2B3B4B5B6B7_B8B9BABBBCBDBEBF;
    localparam logic [127:0] LC = 128'hC0C1C2C3C4C5C6C7_C8C9CACBCCCDCECF;
    localparam logic [127:0] LD = 128'hD0D1D2D3D4D5D6D7_D8D9DADBDCDDDEDF;
    localparam logic [127:0] LE = 128'hE0E1E2E3E4E5E6E7_E8E9EAEBECEDEEEF;

    initial begin
        rst = 1'b1; globstall = 1'b0; wren = 1'b0; rden = 1'b0; mem_ready = 1'b0;
        store_src = 2'b00; phys_addr = 27'd0; cpu_data_in = 64'd0; mem_data_in = 128'd0;
        mem_model[32'h010] = LA; mem_model[32'h090] = LB; mem_model[32'h110] = LC;
        mem_model[32'h190] = LD; mem_model[32'h210] = LE;

        repeat (2) @(posedge clk); #1;
        chk("rst_outputs", {stall, mem_wren, mem_rden, 23'(mem_addr), 64'(cpu_data_out)}, 128'd0);
        chk("rst_mem_data", mem_data_out, 128'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_outputs", {stall, mem_wren, mem_rden, 23'(mem_addr), 64'(cpu_data_out)}, 128'd0);
        @(posedge clk); #1;

        //                wr    rd    sz     addr         wdata               gst  dly miss  wb    wb_addr   wb_data                                  rd_addr  chk   rdata
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000100, 64'h0,               1'b0, 0, 1'b1, 1'b0, 23'h0,    128'h0,                                  23'h010, 1'b1, 64'h8899AABBCCDDEEFF));
        tbl.push_back(mk(1'b1, 1'b0, 2'b00, 27'h0000105, 64'h00000000000000AB, 1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000100, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'h8899ABBBCCDDEEFF));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000900, 64'h0,               1'b0, 1, 1'b1, 1'b0, 23'h0,    128'h0,                                  23'h090, 1'b1, 64'hB8B9BABBBCBDBEBF));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000108, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'h0011223344556677));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0001100, 64'h0,               1'b0, 2, 1'b1, 1'b0, 23'h0,    128'h0,                                  23'h110, 1'b1, 64'hC8C9CACBCCCDCECF));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000100, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'h8899ABBBCCDDEEFF));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000908, 64'h0,               1'b0, 0, 1'b1, 1'b0, 23'h0,    128'h0,                                  23'h090, 1'b1, 64'hB0B1B2B3B4B5B6B7));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0001108, 64'h0,               1'b0, 5, 1'b1, 1'b1, 23'h010, 128'h0011223344556677_8899ABBBCCDDEEFF, 23'h110, 1'b1, 64'hC0C1C2C3C4C5C6C7));
        tbl.push_back(mk(1'b1, 1'b0, 2'b11, 27'h0000908, 64'h123456789ABCDEF0, 1'b1, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0000908, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'hB0B1B2B3B4B5B6B7));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0001100, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'hC8C9CACBCCCDCECF));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0001900, 64'h0,               1'b0, 1, 1'b1, 1'b0, 23'h0,    128'h0,                                  23'h190, 1'b1, 64'hD8D9DADBDCDDDEDF));
        tbl.push_back(mk(1'b1, 1'b0, 2'b01, 27'h0001902, 64'h000000000000BEEF, 1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0001900, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'hD8D9DADBBEEFDEDF));
        tbl.push_back(mk(1'b1, 1'b1, 2'b10, 27'h000110C, 64'h00000000CAFEF00D, 1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b0, 64'h0));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0001108, 64'h0,               1'b0, 0, 1'b0, 1'b0, 23'h0,    128'h0,                                  23'h0,   1'b1, 64'hCAFEF00DC4C5C6C7));
        tbl.push_back(mk(1'b0, 1'b1, 2'b11, 27'h0002100, 64'h0,               1'b0, 3, 1'b1, 1'b1, 23'h190, 128'hD0D1D2D3D4D5D6D7_D8D9DADBBEEFDEDF, 23'h210, 1'b1, 64'hE8E9EAEBECEDEEEF));
        for (int i = 0; i < tbl.size(); i++) begin
            run_req($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of an allocate: rden must drop without a clock edge.
        rden = 1'b1; phys_addr = 27'h0004200;
        @(negedge clk);
        chk("t6_miss_stall", 128'(stall), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_rden", 128'(mem_rden), 128'd1);
        chk("t6_addr", 128'(mem_addr), 128'h420);
        #1 rst = 1'b1;
        #1 chk("t6_async_drop", 128'({mem_wren, mem_rden}), 128'd0);
        @(posedge clk); #1;
        rden = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_req("t6_after", mk(1'b0, 1'b1, 2'b11, 27'h0000100, 64'h0, 1'b0, 0, 1'b1, 1'b0,
                               23'h0, 128'h0, 23'h010, 1'b1, 64'h8899ABBBCCDDEEFF));

        // Randomized traffic on two sets against the reference model.
        do_reset();
        for (int s = 0; s < 128; s++) begin
            m_mru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_val[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
            end
        end
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            int st, tg, off, sz, hw, vw;
            logic [127:0] line;
            st  = $urandom_range(5, 6);
            tg  = $urandom_range(0, 3);
            sz  = $urandom_range(0, 3);
            off = $urandom_range(0, 15) & ~((1 << sz) - 1);
            v = mk(1'($urandom_range(0, 1)), 1'b1, 2'(sz), {16'(tg), 7'(st), 4'(off)},
                   {$urandom, $urandom}, 1'b0, $urandom_range(0, 3), 1'b0, 1'b0,
                   23'h0, 128'h0, 23'h0, 1'b0, 64'h0);
            if (v.wr) v.rd = 1'($urandom_range(0, 1));
            hw = -1;
            for (int w = 0; w < 2; w++)
                if (m_val[st][w] && m_tag[st][w] == 16'(tg)) hw = w;
            if (hw < 0) begin
                vw = !m_val[st][0] ? 0 : (!m_val[st][1] ? 1 : 1 - m_mru[st]);
                v.miss = 1'b1;
                v.wb = m_val[st][vw] && m_dirty[st][vw];
                v.wb_addr = {m_tag[st][vw], 7'(st)};
                v.wb_data = m_line[st][vw];
                v.rd_addr = {16'(tg), 7'(st)};
                m_tag[st][vw] = 16'(tg); m_val[st][vw] = 1'b1; m_dirty[st][vw] = 1'b0;
                m_line[st][vw] = (v.wb && v.wb_addr == v.rd_addr) ? v.wb_data : mem_rd(v.rd_addr);
                hw = vw;
            end else begin
                v.gst = ($urandom_range(0, 7) == 0);
            end
            line = m_line[st][hw];
            v.chk = !v.wr;
            v.rdata = v.addr[3] ? line[127:64] : line[63:0];
            run_req($sformatf("rnd%0d", n), v);
            if (!v.gst) begin
                m_mru[st] = hw;
                if (v.wr) begin
                    for (int b = 0; b < (1 << sz); b++)
                        if (off + b < 16) line[(off + b) * 8 +: 8] = v.wdata[b * 8 +: 8];
                    m_line[st][hw] = line;
                    m_dirty[st][hw] = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
